// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, datapath widths, arbiter FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_OP_W = 4;
  localparam int DATA_W   = 32;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRL = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Anything above the last defined opcode is not a real ALU operation.
  function automatic logic op_illegal(input logic [ALU_OP_W-1:0] op);
    return op > ALU_SRL;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first asserted request after rr_last, wrapping around.
// Latency: purely combinational.
// Backpressure: none; grant is all zero when no request is asserted.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  // Scan from rr_last+1 around to rr_last itself; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_last) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters; round-robin grant, one op in flight. Optional macro ALU_ARB_OPCHK_EN adds resp_err.
// Latency: grant edge -> one EXEC cycle -> response registered; 3 cycles minimum per operation.
// Backpressure: req_ready only in IDLE; response held stable while resp_ready is low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [ALU_OP_W*NUM_REQ-1:0]  req_op,
  input  logic [DATA_W*NUM_REQ-1:0]    req_a,
  input  logic [DATA_W*NUM_REQ-1:0]    req_b,
  output logic [ALU_OP_W-1:0]          alu_op,
  output logic [DATA_W-1:0]            alu_a,
  output logic [DATA_W-1:0]            alu_b,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic                         alu_zero,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [DATA_W-1:0]            resp_result,
`ifdef ALU_ARB_OPCHK_EN
  output logic                         resp_err,
`endif
  output logic                         resp_zero
);

  arb_state_t          state, state_d;
  logic [ID_W-1:0]     rr_last;
  logic [ID_W-1:0]     cur_id;
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic                take;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req_valid),
    .rr_last (rr_last),
    .gnt     (pick_gnt),
    .idx     (pick_idx)
  );

  assign resp_valid = (state == ST_RESP);

  // Next state and grant; requesters are only offered a slot while idle.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = pick_gnt;
        if (|pick_gnt) begin
          take    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_EXEC == state ? ST_RESP : state;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Latch the winner's operands; they drive the ALU and hold until the next grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      cur_id  <= '0;
      rr_last <= ID_W'(NUM_REQ - 1);
    end else if (take) begin
      alu_op  <= req_op[pick_idx*ALU_OP_W +: ALU_OP_W];
      alu_a   <= req_a[pick_idx*DATA_W +: DATA_W];
      alu_b   <= req_b[pick_idx*DATA_W +: DATA_W];
      cur_id  <= pick_idx;
      rr_last <= pick_idx;
    end
  end

  // Capture the ALU output at the end of the execute cycle; stable through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_id     <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      resp_err    <= 1'b0;
`endif
    end else if (state == ST_EXEC) begin
      resp_id     <= cur_id;
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
`ifdef ALU_ARB_OPCHK_EN
      resp_err    <= op_illegal(alu_op);
`endif
    end
  end

endmodule
